// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch definitions: widths, reset origin, HALT encoding, fetch state.
package lc3_pkg;

   localparam int          ADDR_W     = 16;
   localparam int          INSTR_W    = 16;
   localparam logic [15:0] RESET_PC   = 16'h3000;
   localparam logic [15:0] HALT_INSTR = 16'hF025;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

endpackage : lc3_pkg

// File: rtl/lc3_fetch_unit.sv
// LC-3 fetch stage: PC, one-deep instruction register with valid/ready, redirect and halt.
// Optional LC3_FETCH_HALT_DETECT_EN: capturing TRAP x25 (HALT) also stops fetching.
//
// state  | meaning
// IDLE   | out of reset, no capture; run_en starts fetching, redirect only loads pc
// RUN    | fetching one instruction per cycle whenever ir is free or being consumed
// HALTED | no capture; ir drains normally; only a redirect resumes RUN
module lc3_fetch_unit #(
   parameter int                ADDR_W   = lc3_pkg::ADDR_W,
   parameter int                INSTR_W  = lc3_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(lc3_pkg::RESET_PC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] ir,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic [ADDR_W-1:0]  ir_npc,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt_req,
   output logic               halted,
   output logic [ADDR_W-1:0]  pc
);

   import lc3_pkg::*;

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  pc_inc;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
   logic [ADDR_W-1:0]  ir_npc_q, ir_npc_d;
   logic               ir_valid_q, ir_valid_d;
   logic               fire;
   logic               halt_hit;

   // Wraps modulo 2^ADDR_W; ir_npc reuses the same value.
   assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef LC3_FETCH_HALT_DETECT_EN
   assign halt_hit = fire && (imem_data == INSTR_W'(HALT_INSTR));
`else
   assign halt_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (run_en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Redirect outranks both halt sources in the same cycle.
            if (!redirect_valid && (halt_req || halt_hit)) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            if (redirect_valid) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      fire   = (state_q == RUN) && !redirect_valid && (!ir_valid_q || ir_ready);
      halted = (state_q == HALTED);
   end

   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_npc_d   = ir_npc_q;
      ir_valid_d = ir_valid_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc;
         ir_valid_d = 1'b0;
      end else if (fire) begin
         ir_d       = imem_data;
         ir_pc_d    = pc_q;
         ir_npc_d   = pc_inc;
         ir_valid_d = 1'b1;
         pc_d       = pc_inc;
      end else if (ir_ready) begin
         ir_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_npc_q   <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_npc_q   <= ir_npc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign ir_pc     = ir_pc_q;
   assign ir_npc    = ir_npc_q;
   assign ir_valid  = ir_valid_q;

endmodule : lc3_fetch_unit

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit: consumed instructions checked through a scoreboard,
// PC/state/flush behaviour checked directly after each edge.
module tb_lc3_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_en;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic [15:0] ir;
   logic [15:0] ir_pc;
   logic [15:0] ir_npc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt_req;
   logic        halted;
   logic [15:0] pc;

   typedef struct packed {
      logic [15:0] ir;
      logic [15:0] pc;
      logic [15:0] npc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem [0:65535];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   lc3_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .run_en         (run_en),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .ir             (ir),
      .ir_pc          (ir_pc),
      .ir_npc         (ir_npc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .halted         (halted),
      .pc             (pc)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] p, input logic [15:0] n);
      exp_t e;
      e.ir  = i;
      e.pc  = p;
      e.npc = n;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Handshake seen at negedge means the current ir is consumed at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && ir_valid && ir_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got ir %h at %h, expected nothing", ir, ir_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_ir", ir, e.ir);
            chk("sb_ir_pc", ir_pc, e.pc);
            chk("sb_ir_npc", ir_npc, e.npc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
      mem[16'h3000] = 16'h5020;
      mem[16'h3001] = 16'h1261;
      mem[16'h3002] = 16'hF025;
      mem[16'h3003] = 16'h6A01;
      mem[16'h4000] = 16'h2A55;
      mem[16'h4001] = 16'h1234;
      mem[16'hFFFF] = 16'h0000;
      mem[16'h0000] = 16'h7777;

      rst_n = 1'b0; run_en = 1'b0; ir_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 16'h0000; halt_req = 1'b0;
      step(); step();
      chk("rst_pc", pc, 16'h3000);
      chk("rst_imem_addr", imem_addr, 16'h3000);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_ir_pc", ir_pc, 16'h0000);
      chk("rst_ir_npc", ir_npc, 16'h0000);
      chk("rst_valid", 16'(ir_valid), 16'h0);
      chk("rst_halted", 16'(halted), 16'h0);

      rst_n = 1'b1; run_en = 1'b1; ir_ready = 1'b1;
      step();
      chk("idle_no_capture", 16'(ir_valid), 16'h0);
      chk("idle_pc", pc, 16'h3000);
      step();
      chk("cap0_ir", ir, 16'h5020);
      chk("cap0_ir_pc", ir_pc, 16'h3000);
      chk("cap0_ir_npc", ir_npc, 16'h3001);
      chk("cap0_pc", pc, 16'h3001);
      chk("cap0_valid", 16'(ir_valid), 16'h1);

      ir_ready = 1'b0;
      repeat (3) begin
         step();
         chk("stall_ir", ir, 16'h5020);
         chk("stall_pc", pc, 16'h3001);
         chk("stall_valid", 16'(ir_valid), 16'h1);
      end
      push(16'h5020, 16'h3000, 16'h3001);
      ir_ready = 1'b1;
      step();
      chk("cap1_ir", ir, 16'h1261);
      chk("cap1_ir_pc", ir_pc, 16'h3001);
      chk("cap1_pc", pc, 16'h3002);

      ir_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h4000;
      step();
      chk("redir_flush", 16'(ir_valid), 16'h0);
      chk("redir_pc", pc, 16'h4000);
      redirect_valid = 1'b0; ir_ready = 1'b1;
      push(16'h2A55, 16'h4000, 16'h4001);
      step();
      chk("redir_first_ir_pc", ir_pc, 16'h4000);
      chk("redir_first_ir", ir, 16'h2A55);
      step();
      chk("redir_second_ir_pc", ir_pc, 16'h4001);

      // Redirect while ir_ready=1: the 4001 word is discarded, never consumed.
      redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
      step();
      chk("wrap_redir_flush", 16'(ir_valid), 16'h0);
      chk("wrap_redir_pc", pc, 16'hFFFF);
      redirect_valid = 1'b0;
      push(16'h0000, 16'hFFFF, 16'h0000);
      step();
      chk("wrap_pc", pc, 16'h0000);
      chk("wrap_ir_npc", ir_npc, 16'h0000);
      chk("wrap_imem_addr", imem_addr, 16'h0000);

      halt_req = 1'b1;
      push(16'h7777, 16'h0000, 16'h0001);
      step();
      chk("halt_halted", 16'(halted), 16'h1);
      chk("halt_pc", pc, 16'h0001);
      halt_req = 1'b0;
      step(); step();
      chk("halted_hold", 16'(halted), 16'h1);
      chk("halted_pc_frozen", pc, 16'h0001);
      chk("halted_drained", 16'(ir_valid), 16'h0);

      redirect_valid = 1'b1; redirect_pc = 16'h3000;
      step();
      chk("resume_halted", 16'(halted), 16'h0);
      chk("resume_pc", pc, 16'h3000);
      chk("resume_valid", 16'(ir_valid), 16'h0);
      redirect_valid = 1'b0;
      step();
      chk("resume_ir_pc", ir_pc, 16'h3000);
      chk("resume_ir", ir, 16'h5020);
      chk("resume_pc2", pc, 16'h3001);

      halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h3002;
      step();
      chk("halt_vs_redir_halted", 16'(halted), 16'h0);
      chk("halt_vs_redir_pc", pc, 16'h3002);
      chk("halt_vs_redir_valid", 16'(ir_valid), 16'h0);
      halt_req = 1'b0; redirect_valid = 1'b0;
      push(16'hF025, 16'h3002, 16'h3003);
      step();
      chk("f025_ir", ir, 16'hF025);
      chk("f025_pc", pc, 16'h3003);
`ifdef LC3_FETCH_HALT_DETECT_EN
      chk("f025_halted", 16'(halted), 16'h1);
`else
      chk("f025_halted", 16'(halted), 16'h0);
`endif
      step();
`ifdef LC3_FETCH_HALT_DETECT_EN
      chk("post_f025_pc", pc, 16'h3003);
      chk("post_f025_valid", 16'(ir_valid), 16'h0);
      chk("post_f025_halted", 16'(halted), 16'h1);
`else
      chk("post_f025_pc", pc, 16'h3004);
      chk("post_f025_ir", ir, 16'h6A01);
      chk("post_f025_ir_pc", ir_pc, 16'h3003);
      chk("post_f025_valid", 16'(ir_valid), 16'h1);
`endif
      ir_ready = 1'b0;
      step();
`ifdef LC3_FETCH_HALT_DETECT_EN
      chk("pre_rst_pc", pc, 16'h3003);
`else
      chk("pre_rst_pc", pc, 16'h3004);
      chk("pre_rst_valid", 16'(ir_valid), 16'h1);
`endif

      rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h5555;
      step();
      chk("mid_rst_pc", pc, 16'h3000);
      chk("mid_rst_valid", 16'(ir_valid), 16'h0);
      chk("mid_rst_halted", 16'(halted), 16'h0);
      chk("mid_rst_ir", ir, 16'h0000);
      chk("mid_rst_ir_pc", ir_pc, 16'h0000);

      rst_n = 1'b1; redirect_valid = 1'b0; run_en = 1'b0; ir_ready = 1'b1;
      step();
      chk("idle_again_pc", pc, 16'h3000);
      chk("idle_again_valid", 16'(ir_valid), 16'h0);
      redirect_valid = 1'b1; redirect_pc = 16'h4000;
      step();
      chk("idle_redir_pc", pc, 16'h4000);
      chk("idle_redir_halted", 16'(halted), 16'h0);
      redirect_valid = 1'b0;
      step();
      chk("idle_stays_pc", pc, 16'h4000);
      chk("idle_stays_valid", 16'(ir_valid), 16'h0);

      chk("sb_drained", 16'(sb.size()), 16'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_lc3_fetch_unit
